mnist_load_ctrl: RTL
====================

Name: mnist_load_ctrl

Overview:
- Host-side initiator for the network top's off-chip load/compute interface.
- Accepts a 1-bit serial stream of weights then inputs from a host.
- Drives the weight/input memory write port (bank select, address, data, write strobe) while holding memory ownership.
- Then hands memory to the compute engine, waits for the finish flag, and captures the 4-bit classification result.

Parameters:
- W_ADDR_LEN, 20, weight memory address width.
- X_ADDR_LEN, 10, input memory address width.
- W_SEL_LEN, 2, weight bank select width.
- X_SEL_LEN, 2, input bank select width.
- W_WORDS, 100352, weight bits per weight bank; must be ≤ 2^W_ADDR_LEN.
- W_BANKS, 2, number of weight banks loaded; must be ≤ 2^W_SEL_LEN.
- X_WORDS, 784, input bits per input bank; must be ≤ 2^X_ADDR_LEN.
- X_BANKS, 1, number of input banks loaded; must be ≤ 2^X_SEL_LEN.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a run; sampled in IDLE only.
- skip_w  in  1  sampled with start; 1 = skip weight load, load inputs only.
- s_valid  in  1  host stream bit valid.
- s_bit  in  1  host stream data bit.
- s_ready  out  1  controller accepts s_bit this cycle.
- load_compute_ctrl  out  1  1 = host owns memory, 0 = compute engine owns memory.
- en_compute  out  1  compute enable.
- w_wq_oc  out  1  weight memory write strobe.
- x_wq_oc  out  1  input memory write strobe.
- w_addr_oc  out  W_ADDR_LEN  weight write address.
- x_addr_oc  out  X_ADDR_LEN  input write address.
- w_sel_oc  out  W_SEL_LEN  weight bank select.
- x_sel_oc  out  X_SEL_LEN  input bank select.
- wx_write_oc  out  1  write data bit.
- compute_finish  in  1  compute engine done, level.
- result  in  4  compute engine classification.
- result_q  out  4  captured result.
- done  out  1  one-cycle pulse when result_q updates.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - load_compute_ctrl=1.
  - en_compute, strobes, s_ready, done, busy = 0.
  - All addr/sel/data and result_q = 0.
  - State = IDLE.
- Reset mid-operation aborts immediately to these values. Memory contents are not restored.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, W_ACC, W_WR, X_ACC, X_WR, COMPUTE, FIN.
- IDLE:
  - start=1 with skip_w=0 → W_ACC.
  - start=1 with skip_w=1 → X_ACC.
  - Counters cleared on exit. s_valid ignored.
- Write handshake (2 cycles per bit):
  - In *_ACC, s_ready=1.
  - On s_valid&&s_ready: register s_bit into wx_write_oc, present the current counter on addr/sel, go to *_WR.
  - In *_WR: s_ready=0, the matching strobe is 1 for exactly one cycle, and addr/sel/data are held stable.
  - Addr/sel/data also stay stable through the following ACC cycle until the next accept.
  - Without s_valid, *_ACC waits indefinitely with strobes 0.
- Counter ordering (bank-major):
  - Address 0..WORDS-1 within a bank, then sel+1 with address back to 0.
  - After the W_WR of bank W_BANKS-1, address W_WORDS-1 → X_ACC with x counters at 0.
  - After the X_WR of the last input bit → COMPUTE.
- COMPUTE:
  - First cycle: load_compute_ctrl=0, en_compute=1.
  - Held until compute_finish is sampled 1.
  - Then capture result into result_q, drop en_compute, set load_compute_ctrl=1, go to FIN.
  - If compute_finish is already high on the first COMPUTE cycle, it is not honoured. Finish is accepted only from the second COMPUTE cycle on, so a stale flag is never used.
- FIN: done=1 for one cycle → IDLE.
- start during any non-IDLE state is ignored.
- load_compute_ctrl is 1 in every state except COMPUTE.
- Both strobes are never high together.
- No strobe is ever high while load_compute_ctrl=0.

Decomposition:
- Shared package (`define header):
  - FSM state encodings (3-bit).
  - Default W_WORDS/X_WORDS/bank counts, so the top level and the bench agree.
- Natural sub-module: mnist_load_addr_gen.
  - Parameterised bank/address counter with clear, advance, and last-flag output.
  - Instantiated once for weights and once for inputs.

Test Plan (W_WORDS=4, W_BANKS=2, X_WORDS=3, X_BANKS=1 unless noted):
- Full load:
  - Stimulus: start, skip_w=0, s_valid held 1, bits 1,0,1,1,0,0,1,0 then 1,1,0.
  - Required response:
    - 8 w_wq_oc pulses with (sel,addr) = (0,0..3),(1,0..3) and data matching the bits.
    - Then 3 x_wq_oc pulses at addr 0..2.
    - Each pulse 2 cycles apart; strobes never overlap.
- Stalled stream:
  - Stimulus: s_valid low 5 cycles between bit 2 and bit 3.
  - Required response: no strobe and addr stable during the gap; the bit lands at addr 2.
- Compute handshake:
  - Stimulus: compute_finish rises 7 cycles after entering COMPUTE with result=4'd7.
  - Required response:
    - load_compute_ctrl=0 and en_compute=1 for those cycles.
    - result_q=7 and done pulse 1 cycle after capture; then IDLE with busy=0.
- skip_w:
  - Stimulus: start with skip_w=1.
  - Required response: zero w_wq_oc pulses; only 3 x writes; then COMPUTE.
- Stale finish and ignored start:
  - Stimulus: compute_finish held 1 on entering COMPUTE; start pulsed during load.
  - Required response: en_compute still high at least one cycle before capture; the run is not restarted.
- Reset mid-load:
  - Stimulus: rst asserted after 5 weight bits, asynchronously mid-cycle.
  - Required response:
    - Outputs go to reset values immediately, with load_compute_ctrl=1.
    - A new start restarts at sel=0, addr=0.

Source files
------------

// File: rtl/mnist_load_ctrl_pkg.sv
// Shared types and default geometry for the MNIST load controller and its bench.
// The top level and the testbench both take their defaults from here.
package mnist_load_ctrl_pkg;

  localparam int W_ADDR_LEN_DEF = 20;
  localparam int X_ADDR_LEN_DEF = 10;
  localparam int W_SEL_LEN_DEF  = 2;
  localparam int X_SEL_LEN_DEF  = 2;
  localparam int W_WORDS_DEF    = 100352;
  localparam int W_BANKS_DEF    = 2;
  localparam int X_WORDS_DEF    = 784;
  localparam int X_BANKS_DEF    = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W_ACC   = 3'd1,
    ST_W_WR    = 3'd2,
    ST_X_ACC   = 3'd3,
    ST_X_WR    = 3'd4,
    ST_COMPUTE = 3'd5,
    ST_FIN     = 3'd6
  } state_e;

  // The host keeps memory ownership everywhere except while the engine computes.
  function automatic logic host_owns(input state_e s);
    return s != ST_COMPUTE;
  endfunction

endpackage

// File: rtl/mnist_load_ctrl_if.sv
// Memory write port and compute handshake between the load controller (master)
// and the network top (slave).
interface mnist_load_ctrl_if
  import mnist_load_ctrl_pkg::*;
#(
  parameter int W_ADDR_LEN = W_ADDR_LEN_DEF,
  parameter int X_ADDR_LEN = X_ADDR_LEN_DEF,
  parameter int W_SEL_LEN  = W_SEL_LEN_DEF,
  parameter int X_SEL_LEN  = X_SEL_LEN_DEF
) ();

  logic                  load_compute_ctrl;
  logic                  en_compute;
  logic                  w_wq_oc;
  logic                  x_wq_oc;
  logic [W_ADDR_LEN-1:0] w_addr_oc;
  logic [X_ADDR_LEN-1:0] x_addr_oc;
  logic [W_SEL_LEN-1:0]  w_sel_oc;
  logic [X_SEL_LEN-1:0]  x_sel_oc;
  logic                  wx_write_oc;
  logic                  compute_finish;
  logic [3:0]            result;

  modport master (
    output load_compute_ctrl, en_compute, w_wq_oc, x_wq_oc,
           w_addr_oc, x_addr_oc, w_sel_oc, x_sel_oc, wx_write_oc,
    input  compute_finish, result
  );

  modport slave (
    input  load_compute_ctrl, en_compute, w_wq_oc, x_wq_oc,
           w_addr_oc, x_addr_oc, w_sel_oc, x_sel_oc, wx_write_oc,
    output compute_finish, result
  );

endinterface

// File: rtl/mnist_load_addr_gen.sv
// Bank-major address counter: address runs 0..WORDS-1, then bank select steps.
// 'last' flags the final word of the final bank.
module mnist_load_addr_gen
  import mnist_load_ctrl_pkg::*;
#(
  parameter int ADDR_LEN = W_ADDR_LEN_DEF,
  parameter int SEL_LEN  = W_SEL_LEN_DEF,
  parameter int WORDS    = W_WORDS_DEF,
  parameter int BANKS    = W_BANKS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                adv,
  output logic [ADDR_LEN-1:0] addr,
  output logic [SEL_LEN-1:0]  sel,
  output logic                last
);

  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(WORDS - 1);
  localparam logic [SEL_LEN-1:0]  LAST_SEL  = SEL_LEN'(BANKS - 1);

  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [SEL_LEN-1:0]  sel_q, sel_d;

  always_comb begin
    addr_d = addr_q;
    sel_d  = sel_q;
    if (clr) begin
      addr_d = '0;
      sel_d  = '0;
    end else if (adv) begin
      if (addr_q == LAST_ADDR) begin
        addr_d = '0;
        sel_d  = sel_q + 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      sel_q  <= '0;
    end else begin
      addr_q <= addr_d;
      sel_q  <= sel_d;
    end
  end

  assign addr = addr_q;
  assign sel  = sel_q;
  assign last = (addr_q == LAST_ADDR) && (sel_q == LAST_SEL);

endmodule

// File: rtl/mnist_load_ctrl.sv
// Host-side loader: streams serial weight/input bits into the network memories,
// then hands memory to the compute engine and captures its classification.
module mnist_load_ctrl
  import mnist_load_ctrl_pkg::*;
#(
  parameter int W_ADDR_LEN = W_ADDR_LEN_DEF,
  parameter int X_ADDR_LEN = X_ADDR_LEN_DEF,
  parameter int W_SEL_LEN  = W_SEL_LEN_DEF,
  parameter int X_SEL_LEN  = X_SEL_LEN_DEF,
  parameter int W_WORDS    = W_WORDS_DEF,
  parameter int W_BANKS    = W_BANKS_DEF,
  parameter int X_WORDS    = X_WORDS_DEF,
  parameter int X_BANKS    = X_BANKS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       skip_w,
  input  logic       s_valid,
  input  logic       s_bit,
  output logic       s_ready,
  output logic [3:0] result_q,
  output logic       done,
  output logic       busy,
  mnist_load_ctrl_if.master bus
);

  state_e state_q, state_d;

  logic                  s_ready_q, s_ready_d;
  logic                  lcc_q, lcc_d;
  logic                  en_q, en_d;
  logic                  w_wq_q, w_wq_d;
  logic                  x_wq_q, x_wq_d;
  logic [W_ADDR_LEN-1:0] w_addr_q, w_addr_d;
  logic [X_ADDR_LEN-1:0] x_addr_q, x_addr_d;
  logic [W_SEL_LEN-1:0]  w_sel_q, w_sel_d;
  logic [X_SEL_LEN-1:0]  x_sel_q, x_sel_d;
  logic                  wdat_q, wdat_d;
  logic [3:0]            result_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  first_q, first_d;

  logic                  w_clr, w_adv, w_last;
  logic                  x_clr, x_adv, x_last;
  logic [W_ADDR_LEN-1:0] w_addr_cnt;
  logic [W_SEL_LEN-1:0]  w_sel_cnt;
  logic [X_ADDR_LEN-1:0] x_addr_cnt;
  logic [X_SEL_LEN-1:0]  x_sel_cnt;
  logic                  accept;

  mnist_load_addr_gen #(
    .ADDR_LEN(W_ADDR_LEN), .SEL_LEN(W_SEL_LEN), .WORDS(W_WORDS), .BANKS(W_BANKS)
  ) u_w_gen (
    .clk(clk), .rst(rst), .clr(w_clr), .adv(w_adv),
    .addr(w_addr_cnt), .sel(w_sel_cnt), .last(w_last)
  );

  mnist_load_addr_gen #(
    .ADDR_LEN(X_ADDR_LEN), .SEL_LEN(X_SEL_LEN), .WORDS(X_WORDS), .BANKS(X_BANKS)
  ) u_x_gen (
    .clk(clk), .rst(rst), .clr(x_clr), .adv(x_adv),
    .addr(x_addr_cnt), .sel(x_sel_cnt), .last(x_last)
  );

  assign accept = s_valid && s_ready_q;

  always_comb begin
    state_d  = state_q;
    w_addr_d = w_addr_q;
    x_addr_d = x_addr_q;
    w_sel_d  = w_sel_q;
    x_sel_d  = x_sel_q;
    wdat_d   = wdat_q;
    result_d = result_q;
    w_clr    = 1'b0;
    w_adv    = 1'b0;
    x_clr    = 1'b0;
    x_adv    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        w_clr = 1'b1;
        x_clr = 1'b1;
        if (start) state_d = skip_w ? ST_X_ACC : ST_W_ACC;
      end
      ST_W_ACC: begin
        if (accept) begin
          wdat_d   = s_bit;
          w_addr_d = w_addr_cnt;
          w_sel_d  = w_sel_cnt;
          state_d  = ST_W_WR;
        end
      end
      ST_W_WR: begin
        w_adv   = 1'b1;
        state_d = w_last ? ST_X_ACC : ST_W_ACC;
      end
      ST_X_ACC: begin
        if (accept) begin
          wdat_d   = s_bit;
          x_addr_d = x_addr_cnt;
          x_sel_d  = x_sel_cnt;
          state_d  = ST_X_WR;
        end
      end
      ST_X_WR: begin
        x_adv   = 1'b1;
        state_d = x_last ? ST_COMPUTE : ST_X_ACC;
      end
      ST_COMPUTE: begin
        // A finish flag left high from a previous run is ignored on the first cycle.
        if (!first_q && bus.compute_finish) begin
          result_d = bus.result;
          state_d  = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    s_ready_d = (state_d == ST_W_ACC) || (state_d == ST_X_ACC);
    w_wq_d    = (state_d == ST_W_WR);
    x_wq_d    = (state_d == ST_X_WR);
    lcc_d     = host_owns(state_d);
    en_d      = (state_d == ST_COMPUTE);
    done_d    = (state_d == ST_FIN);
    busy_d    = (state_d != ST_IDLE);
    first_d   = (state_d == ST_COMPUTE) && (state_q != ST_COMPUTE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      s_ready_q <= 1'b0;
      lcc_q     <= 1'b1;
      en_q      <= 1'b0;
      w_wq_q    <= 1'b0;
      x_wq_q    <= 1'b0;
      w_addr_q  <= '0;
      x_addr_q  <= '0;
      w_sel_q   <= '0;
      x_sel_q   <= '0;
      wdat_q    <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      lcc_q     <= lcc_d;
      en_q      <= en_d;
      w_wq_q    <= w_wq_d;
      x_wq_q    <= x_wq_d;
      w_addr_q  <= w_addr_d;
      x_addr_q  <= x_addr_d;
      w_sel_q   <= w_sel_d;
      x_sel_q   <= x_sel_d;
      wdat_q    <= wdat_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      first_q   <= first_d;
    end
  end

  assign s_ready               = s_ready_q;
  assign done                  = done_q;
  assign busy                  = busy_q;
  assign bus.load_compute_ctrl = lcc_q;
  assign bus.en_compute        = en_q;
  assign bus.w_wq_oc           = w_wq_q;
  assign bus.x_wq_oc           = x_wq_q;
  assign bus.w_addr_oc         = w_addr_q;
  assign bus.x_addr_oc         = x_addr_q;
  assign bus.w_sel_oc          = w_sel_q;
  assign bus.x_sel_oc          = x_sel_q;
  assign bus.wx_write_oc       = wdat_q;

endmodule
